// File: rtl/ysyx_25060170_wbu_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25060170_wbu_if
// Description : Writeback-unit bus bundle: result input handshake, register
//               file write port, commit report and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_25060170_wbu_if;
    // upstream result handshake
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rwen;
    logic [31:0] in_res;
    logic        in_is_load;
    logic [2:0]  in_ldtype;
    logic [1:0]  in_addr_lo;
    // register-file write port
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        gpr_ready;
    // retire report and status
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] pend_mask;
    logic [31:0] commit_cnt;
    logic        err;

    modport master (
        output in_valid, in_pc, in_rd, in_rwen, in_res, in_is_load,
               in_ldtype, in_addr_lo, gpr_ready,
        input  in_ready, gpr_wen, gpr_waddr, gpr_wdata, commit_valid,
               commit_pc, pend_mask, commit_cnt, err
    );

    modport slave (
        input  in_valid, in_pc, in_rd, in_rwen, in_res, in_is_load,
               in_ldtype, in_addr_lo, gpr_ready,
        output in_ready, gpr_wen, gpr_waddr, gpr_wdata, commit_valid,
               commit_pc, pend_mask, commit_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_25060170_wbu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25060170_wbu
// Description : Writeback unit. Queues retiring results, aligns load data at
//               enqueue, writes the register file from the queue head and
//               reports each retire one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25060170_wbu #(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_25060170_wbu_if.slave    bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    // queue storage (no reset needed: validity comes from count_q)
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [4:0]  rd_q   [DEPTH];
    logic        rwen_q [DEPTH];
    logic        ill_q  [DEPTH];

    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          commit_valid_q, commit_valid_d;
    logic [31:0]   commit_pc_q, commit_pc_d;
    logic [31:0]   commit_cnt_q, commit_cnt_d;
    logic          err_q, err_d;

    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;
    logic [31:0] w_data;
    logic        w_ill;
    logic [31:0] w_pend;

    // no full-bypass: a full queue only accepts again after count drops
    assign w_ready = (count_q < c_DEPTH);
    assign w_push  = bus.in_valid & w_ready;
    assign w_pop   = (count_q != '0) & bus.gpr_ready;

    assign w_byte = bus.in_res[{bus.in_addr_lo, 3'b000} +: 8];
    assign w_half = bus.in_addr_lo[1] ? bus.in_res[31:16] : bus.in_res[15:0];

    // load alignment and extension, done once at enqueue
    always_comb begin
        w_ld = bus.in_res;
        case (bus.in_ldtype)
            3'd0:    w_ld = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_ld = {{16{w_half[15]}}, w_half};
            3'd4:    w_ld = {24'd0, w_byte};
            3'd5:    w_ld = {16'd0, w_half};
            default: w_ld = bus.in_res;
        endcase
    end

    assign w_data = bus.in_is_load ? w_ld : bus.in_res;

    // misaligned half/word loads and reserved load types retire without a write
    assign w_ill = bus.in_is_load &
                   (((bus.in_ldtype[1:0] == 2'b01) & bus.in_addr_lo[0]) |
                    ((bus.in_ldtype == 3'd2) & (bus.in_addr_lo != 2'd0)) |
                    (bus.in_ldtype == 3'd3) |
                    (bus.in_ldtype == 3'd6) |
                    (bus.in_ldtype == 3'd7));

    // next-state for pointers, occupancy and commit reporting
    always_comb begin
        rptr_d         = rptr_q + PW'(w_pop);
        wptr_d         = wptr_q + PW'(w_push);
        count_d        = count_q + CW'(w_push) - CW'(w_pop);
        commit_valid_d = w_pop;
        commit_pc_d    = w_pop ? pc_q[rptr_q] : commit_pc_q;
        commit_cnt_d   = commit_cnt_q + 32'(w_pop);
        err_d          = err_q | (w_pop & ill_q[rptr_q]);
    end

    // control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q         <= '0;
            wptr_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_cnt_q   <= '0;
            err_q          <= 1'b0;
        end else begin
            rptr_q         <= rptr_d;
            wptr_q         <= wptr_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_cnt_q   <= commit_cnt_d;
            err_q          <= err_d;
        end
    end

    // write the accepted entry at the tail; reset suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            pc_q[wptr_q]   <= bus.in_pc;
            data_q[wptr_q] <= w_data;
            rd_q[wptr_q]   <= bus.in_rd;
            rwen_q[wptr_q] <= bus.in_rwen;
            ill_q[wptr_q]  <= w_ill;
        end
    end

    // pending-destination mask over the occupied slots, x0 never reported
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && rwen_q[rptr_q + PW'(i)] &&
                (rd_q[rptr_q + PW'(i)] != 5'd0)) begin
                w_pend[rd_q[rptr_q + PW'(i)]] = 1'b1;
            end
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.gpr_waddr    = rd_q[rptr_q];
    assign bus.gpr_wdata    = data_q[rptr_q];
    assign bus.gpr_wen      = w_pop & rwen_q[rptr_q] &
                              (rd_q[rptr_q] != 5'd0) & ~ill_q[rptr_q];
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_pc    = commit_pc_q;
    assign bus.commit_cnt   = commit_cnt_q;
    assign bus.err          = err_q;
    assign bus.pend_mask    = w_pend;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_wbu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25060170_wbu
// Description : Scoreboard bench for the writeback unit: directed scenarios
//               followed by random traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060170_wbu;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rwen;
        logic [31:0] data;
        logic        ill;
    } ent_t;

    logic clk;
    logic rst;
    ysyx_25060170_wbu_if bus_if();

    ysyx_25060170_wbu #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    ent_t        exp_q[$];
    logic [31:0] exp_cnt = 32'd0;
    bit          exp_err = 1'b0;
    bit          exp_cv  = 1'b0;
    logic [31:0] exp_cpc = 32'd0;
    bit          mon_en  = 1'b0;

    int          m_sz;
    bit          m_wen;
    logic [31:0] m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // aligned load value from byte/halfword arithmetic
    function automatic logic [31:0] ref_data(input logic [31:0] res, input logic is_load,
                                             input logic [2:0] lt, input logic [1:0] lo);
        int unsigned b;
        int unsigned h;
        if (!is_load) return res;
        b = (res >> (8 * int'(lo))) % 256;
        h = (res >> (16 * (int'(lo) / 2))) % 65536;
        case (lt)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd5:    return 32'(h);
            default: return res;
        endcase
    endfunction

    function automatic bit ref_ill(input logic is_load, input logic [2:0] lt, input logic [1:0] lo);
        if (!is_load) return 1'b0;
        if (lt == 3'd3 || lt >= 3'd6) return 1'b1;
        if ((lt == 3'd1 || lt == 3'd5) && (int'(lo) % 2 == 1)) return 1'b1;
        if (lt == 3'd2 && lo != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    // model: track the queue contents edge by edge from the inputs only
    initial begin
        int   sz;
        bit   pop;
        bit   push;
        ent_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                exp_cnt = 32'd0;
                exp_err = 1'b0;
                exp_cv  = 1'b0;
                exp_cpc = 32'd0;
            end else begin
                sz   = exp_q.size();
                pop  = (sz > 0) && bus_if.gpr_ready;
                push = bus_if.in_valid && (sz < DEPTH);
                exp_cv = pop;
                if (pop) begin
                    e = exp_q.pop_front();
                    exp_cpc = e.pc;
                    exp_cnt = exp_cnt + 32'd1;
                    if (e.ill) exp_err = 1'b1;
                end
                if (push) begin
                    e.pc   = bus_if.in_pc;
                    e.rd   = bus_if.in_rd;
                    e.rwen = bus_if.in_rwen;
                    e.data = ref_data(bus_if.in_res, bus_if.in_is_load,
                                      bus_if.in_ldtype, bus_if.in_addr_lo);
                    e.ill  = ref_ill(bus_if.in_is_load, bus_if.in_ldtype, bus_if.in_addr_lo);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // monitor: compare every DUT output against the model on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                m_sz  = exp_q.size();
                m_wen = (m_sz > 0) && bus_if.gpr_ready && exp_q[0].rwen &&
                        (exp_q[0].rd != 5'd0) && !exp_q[0].ill;
                chk("in_ready", 32'(bus_if.in_ready), 32'(m_sz < DEPTH));
                chk("gpr_wen", 32'(bus_if.gpr_wen), 32'(m_wen));
                if (m_sz > 0) begin
                    chk("gpr_waddr", 32'(bus_if.gpr_waddr), 32'(exp_q[0].rd));
                    if (!exp_q[0].ill) chk("gpr_wdata", bus_if.gpr_wdata, exp_q[0].data);
                end
                m_pend = 32'd0;
                foreach (exp_q[k]) begin
                    if (exp_q[k].rwen && exp_q[k].rd != 5'd0) m_pend = m_pend | (32'd1 << exp_q[k].rd);
                end
                chk("pend_mask", bus_if.pend_mask, m_pend);
                chk("commit_valid", 32'(bus_if.commit_valid), 32'(exp_cv));
                if (exp_cv) chk("commit_pc", bus_if.commit_pc, exp_cpc);
                chk("commit_cnt", bus_if.commit_cnt, exp_cnt);
                chk("err", 32'(bus_if.err), 32'(exp_err));
            end
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic rwen,
                         input logic [31:0] res, input logic isl, input logic [2:0] lt,
                         input logic [1:0] lo);
        bus_if.in_valid   = 1'b1;
        bus_if.in_pc      = pc;
        bus_if.in_rd      = rd;
        bus_if.in_rwen    = rwen;
        bus_if.in_res     = res;
        bus_if.in_is_load = isl;
        bus_if.in_ldtype  = lt;
        bus_if.in_addr_lo = lo;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // one entry through an idle queue with gpr_ready high; check head wdata
    task automatic single(input logic [31:0] pc, input logic [4:0] rd, input logic rwen,
                          input logic [31:0] res, input logic isl, input logic [2:0] lt,
                          input logic [1:0] lo, input string name, input logic [31:0] wd);
        step();
        drive(pc, rd, rwen, res, isl, lt, lo);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk(name, bus_if.gpr_wdata, wd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus_if.gpr_ready = 1'b0;
        drive(32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
        bus_if.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_pend", bus_if.pend_mask, 32'd0);
        chk("rst_cnt", bus_if.commit_cnt, 32'd0);
        chk("rst_wen", 32'(bus_if.gpr_wen), 32'd0);

        // basic retire
        bus_if.gpr_ready = 1'b1;
        step();
        drive(32'h8000_0000, 5'd5, 1'b1, 32'h1234, 1'b0, 3'd2, 2'd0);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("basic_wen", 32'(bus_if.gpr_wen), 32'd1);
        chk("basic_waddr", 32'(bus_if.gpr_waddr), 32'd5);
        chk("basic_wdata", bus_if.gpr_wdata, 32'h1234);
        @(negedge clk);
        chk("basic_cv", 32'(bus_if.commit_valid), 32'd1);
        chk("basic_cpc", bus_if.commit_pc, 32'h8000_0000);
        chk("basic_cnt", bus_if.commit_cnt, 32'd1);

        // load alignment
        single(32'h100, 5'd6, 1'b1, 32'h80FF7F01, 1'b1, 3'd0, 2'd3, "lb_a3", 32'hFFFFFF80);
        single(32'h104, 5'd6, 1'b1, 32'h80FF7F01, 1'b1, 3'd5, 2'd2, "lhu_a2", 32'h000080FF);
        single(32'h108, 5'd6, 1'b1, 32'h80FF7F01, 1'b1, 3'd1, 2'd0, "lh_a0", 32'h00007F01);

        // back-pressure fills the queue, then drains in order
        step();
        bus_if.gpr_ready = 1'b0;
        drive(32'h200, 5'd1, 1'b1, 32'hAAAA, 1'b0, 3'd0, 2'd0);
        step();
        drive(32'h204, 5'd2, 1'b1, 32'hBBBB, 1'b0, 3'd0, 2'd0);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("full_pend", bus_if.pend_mask, 32'h6);
        chk("full_wen", 32'(bus_if.gpr_wen), 32'd0);
        #1;
        bus_if.gpr_ready = 1'b1;
        #1;
        chk("drain1_wen", 32'(bus_if.gpr_wen), 32'd1);
        chk("drain1_waddr", 32'(bus_if.gpr_waddr), 32'd1);
        @(negedge clk);
        chk("drain2_wen", 32'(bus_if.gpr_wen), 32'd1);
        chk("drain2_waddr", 32'(bus_if.gpr_waddr), 32'd2);
        @(negedge clk);
        chk("drained_pend", bus_if.pend_mask, 32'd0);

        // misaligned lw: no write, sticky err
        step();
        drive(32'h300, 5'd7, 1'b1, 32'h55AA55AA, 1'b1, 3'd2, 2'd2);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("ill_wen", 32'(bus_if.gpr_wen), 32'd0);
        @(negedge clk);
        chk("ill_cv", 32'(bus_if.commit_valid), 32'd1);
        chk("ill_err", 32'(bus_if.err), 32'd1);
        repeat (3) @(negedge clk);
        chk("ill_err_sticky", 32'(bus_if.err), 32'd1);

        // write to x0 is suppressed but still retires
        step();
        drive(32'h400, 5'd0, 1'b1, 32'hDEAD, 1'b0, 3'd0, 2'd0);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("x0_wen", 32'(bus_if.gpr_wen), 32'd0);
        @(negedge clk);
        chk("x0_cv", 32'(bus_if.commit_valid), 32'd1);
        chk("x0_cnt", bus_if.commit_cnt, 32'd8);

        // reset flushes a full queue without writing it
        step();
        bus_if.gpr_ready = 1'b0;
        drive(32'h500, 5'd3, 1'b1, 32'h3333, 1'b0, 3'd0, 2'd0);
        step();
        drive(32'h504, 5'd4, 1'b1, 32'h4444, 1'b0, 3'd0, 2'd0);
        step();
        drive(32'h508, 5'd9, 1'b1, 32'h9999, 1'b0, 3'd0, 2'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("flush_pend", bus_if.pend_mask, 32'd0);
        chk("flush_cnt", bus_if.commit_cnt, 32'd0);
        chk("flush_err", 32'(bus_if.err), 32'd0);
        #1;
        bus_if.gpr_ready = 1'b1;
        #1;
        chk("flush_wen", 32'(bus_if.gpr_wen), 32'd0);
        @(negedge clk);
        chk("flush_cv", 32'(bus_if.commit_valid), 32'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            bus_if.in_valid   = ($urandom_range(0, 9) < 6);
            bus_if.in_pc      = $urandom;
            bus_if.in_rd      = 5'($urandom_range(0, 31));
            bus_if.in_rwen    = ($urandom_range(0, 3) != 0);
            bus_if.in_res     = $urandom;
            bus_if.in_is_load = ($urandom_range(0, 1) == 1);
            bus_if.in_ldtype  = 3'($urandom_range(0, 7));
            bus_if.in_addr_lo = 2'($urandom_range(0, 3));
            bus_if.gpr_ready  = ($urandom_range(0, 9) < 7);
            rst               = ($urandom_range(0, 299) == 0);
        end
        step();
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.gpr_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
